// File: rtl/eth_rx_cfg_pkg.sv
// Shared types for the eth RX steering-CAM configuration controller:
// FSM states, message type codes, op/status encodings and the packed
// layouts of the header and body flits (both sit at the MSB end of a flit).
package eth_rx_cfg_pkg;

    // Field widths baked into the flit layouts below.
    localparam int XY_W_P       = 4;
    localparam int ETH_TYPE_W_P = 16;

    localparam logic [7:0] MSG_CFG = 8'h30;
    localparam logic [7:0] MSG_ACK = 8'h31;

    typedef enum logic [2:0] {
        ST_RX_HDR  = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_RX_BODY = 3'd2,
        ST_CAM_WR  = 3'd3,
        ST_TX_ACK  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OP_BAD0  = 2'b00,
        OP_WRITE = 2'b01,
        OP_INVAL = 2'b10,
        OP_BAD3  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        STS_OK      = 2'b00,
        STS_BAD_MSG = 2'b01,
        STS_BAD_OP  = 2'b10,
        STS_BAD_IDX = 2'b11
    } status_e;

    typedef struct packed {
        logic [XY_W_P-1:0] dst_x;
        logic [XY_W_P-1:0] dst_y;
        logic [XY_W_P-1:0] src_x;
        logic [XY_W_P-1:0] src_y;
        logic [7:0]        msg_len;
        logic [7:0]        msg_type;
    } hdr_t;

    typedef struct packed {
        op_e                     op;
        logic [7:0]              idx;
        logic [ETH_TYPE_W_P-1:0] tag;
        logic [XY_W_P-1:0]       dst_x;
        logic [XY_W_P-1:0]       dst_y;
    } body_t;

    localparam int HDR_W  = $bits(hdr_t);
    localparam int BODY_W = $bits(body_t);

    function automatic logic op_valid(input op_e op);
        return (op == OP_WRITE) || (op == OP_INVAL);
    endfunction

endpackage

// File: rtl/eth_rx_cam_cfg_ctrl_if.sv
// Bus bundle between the noc0 config port, the ack return port and the
// CAM write port.
//   slave  : the controller (consumes config flits, produces acks/CAM writes)
//   master : the environment (noc0 router, RX lookup, CAM)
interface eth_rx_cam_cfg_ctrl_if #(
    parameter int NOC_DATA_W = 512,
    parameter int XY_W       = 4,
    parameter int ETH_TYPE_W = 16,
    parameter int IDX_W      = 3
);
    logic                  noc0_ctovr_cfg_val;
    logic [NOC_DATA_W-1:0] noc0_ctovr_cfg_data;
    logic                  cfg_noc0_ctovr_rdy;
    logic                  cfg_noc0_vrtoc_val;
    logic [NOC_DATA_W-1:0] cfg_noc0_vrtoc_data;
    logic                  noc0_vrtoc_cfg_rdy;
    logic                  rd_cam_val;
    logic                  cfg_cam_wr_val;
    logic                  cfg_cam_wr_clear;
    logic [IDX_W-1:0]      cfg_cam_wr_idx;
    logic [ETH_TYPE_W-1:0] cfg_cam_wr_tag;
    logic [2*XY_W-1:0]     cfg_cam_wr_data;
    logic [15:0]           cfg_wr_count;

    modport slave (
        input  noc0_ctovr_cfg_val, noc0_ctovr_cfg_data, noc0_vrtoc_cfg_rdy, rd_cam_val,
        output cfg_noc0_ctovr_rdy, cfg_noc0_vrtoc_val, cfg_noc0_vrtoc_data,
               cfg_cam_wr_val, cfg_cam_wr_clear, cfg_cam_wr_idx, cfg_cam_wr_tag,
               cfg_cam_wr_data, cfg_wr_count
    );

    modport master (
        output noc0_ctovr_cfg_val, noc0_ctovr_cfg_data, noc0_vrtoc_cfg_rdy, rd_cam_val,
        input  cfg_noc0_ctovr_rdy, cfg_noc0_vrtoc_val, cfg_noc0_vrtoc_data,
               cfg_cam_wr_val, cfg_cam_wr_clear, cfg_cam_wr_idx, cfg_cam_wr_tag,
               cfg_cam_wr_data, cfg_wr_count
    );

endinterface

// File: rtl/eth_rx_cam_cfg_datap.sv
// Datapath of the CAM config controller: latches the header source and the
// body fields, holds the ack status, assembles the ack flit and keeps the
// count of completed CAM operations.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   hdr_ld, src_*_in      latch sender coordinates from an accepted header
//   body_ld, *_in         latch op/idx/tag/dst from an accepted body flit
//   status_ld, status_in  latch the ack status
//   cnt_inc               a CAM write strobe fired this cycle
//   ack_en                ack flit is being presented (zero otherwise)
//   cam_wr_*              held CAM write fields
//   ack_data              assembled ack flit
//   wr_count              completed CAM ops, wraps at 16 bits
module eth_rx_cam_cfg_datap
    import eth_rx_cfg_pkg::*;
#(
    parameter int NOC_DATA_W = 512,
    parameter int XY_W       = 4,
    parameter int ETH_TYPE_W = 16,
    parameter int IDX_W      = 3,
    parameter int SRC_X      = -1,
    parameter int SRC_Y      = -1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hdr_ld,
    input  logic [XY_W-1:0]       src_x_in,
    input  logic [XY_W-1:0]       src_y_in,
    input  logic                  body_ld,
    input  op_e                   op_in,
    input  logic [IDX_W-1:0]      idx_in,
    input  logic [ETH_TYPE_W-1:0] tag_in,
    input  logic [2*XY_W-1:0]     dst_in,
    input  logic                  status_ld,
    input  status_e               status_in,
    input  logic                  cnt_inc,
    input  logic                  ack_en,
    output logic                  cam_wr_clear,
    output logic [IDX_W-1:0]      cam_wr_idx,
    output logic [ETH_TYPE_W-1:0] cam_wr_tag,
    output logic [2*XY_W-1:0]     cam_wr_data,
    output logic [NOC_DATA_W-1:0] ack_data,
    output logic [15:0]           wr_count
);

    localparam logic [XY_W-1:0] SRC_X_L = XY_W'(SRC_X);
    localparam logic [XY_W-1:0] SRC_Y_L = XY_W'(SRC_Y);

    logic [XY_W-1:0]       src_x_q;
    logic [XY_W-1:0]       src_y_q;
    op_e                   op_q;
    logic [IDX_W-1:0]      idx_q;
    logic [ETH_TYPE_W-1:0] tag_q;
    logic [2*XY_W-1:0]     dst_q;
    status_e               status_q;
    logic [15:0]           wr_count_q;
    hdr_t                  ack_hdr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_x_q    <= '0;
            src_y_q    <= '0;
            op_q       <= OP_BAD0;
            idx_q      <= '0;
            tag_q      <= '0;
            dst_q      <= '0;
            status_q   <= STS_OK;
            wr_count_q <= '0;
        end else begin
            if (hdr_ld) begin
                src_x_q <= src_x_in;
                src_y_q <= src_y_in;
            end
            if (body_ld) begin
                op_q  <= op_in;
                idx_q <= idx_in;
                tag_q <= tag_in;
                dst_q <= dst_in;
            end
            if (status_ld) begin
                status_q <= status_in;
            end
            if (cnt_inc) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    assign cam_wr_clear = (op_q == OP_INVAL);
    assign cam_wr_idx   = idx_q;
    assign cam_wr_tag   = tag_q;
    assign cam_wr_data  = dst_q;
    assign wr_count     = wr_count_q;

    // The ack goes back to whoever sent the config message. The flit is
    // forced to zero when not presented so the port idles at 0.
    always_comb begin
        ack_hdr = '{dst_x: src_x_q, dst_y: src_y_q, src_x: SRC_X_L, src_y: SRC_Y_L,
                    msg_len: 8'd0, msg_type: MSG_ACK};
        ack_data = '0;
        if (ack_en) begin
            ack_data[NOC_DATA_W-1 -: HDR_W] = ack_hdr;
            ack_data[1:0]                   = status_q;
        end
    end

endmodule

// File: rtl/eth_rx_cam_cfg_ctrl.sv
// EtherType steering CAM configuration controller. Accepts one config
// message at a time from noc0, turns it into a CAM write or invalidate that
// yields to live RX lookups, and answers every message with a one-flit ack.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   bus         slave side of eth_rx_cam_cfg_ctrl_if (config in, ack out,
//               RX lookup busy in, CAM write port and op counter out)
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_RX_HDR  | idle, waiting for a message header
// ST_DRAIN   | discarding body flits of a rejected message
// ST_RX_BODY | waiting for the single body flit of a CFG message
// ST_CAM_WR  | write pending, held off while the RX lookup owns the CAM
// ST_TX_ACK  | ack flit presented until noc0 accepts it
module eth_rx_cam_cfg_ctrl
    import eth_rx_cfg_pkg::*;
#(
    parameter int SRC_X       = -1,
    parameter int SRC_Y       = -1,
    parameter int NOC_DATA_W  = 512,
    parameter int XY_W        = 4,
    parameter int ETH_TYPE_W  = 16,
    parameter int NUM_ENTRIES = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    eth_rx_cam_cfg_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    state_e     state_q, state_d;
    logic       run_q;
    logic [7:0] drain_q, drain_d;
    hdr_t       hdr_in;
    body_t      body_in;
    logic       rdy;
    logic       accept;
    logic       wr_fire;
    logic       ack_en;
    logic       hdr_ld;
    logic       body_ld;
    logic       status_ld;
    status_e    status_d;
    logic       unused_bits;

    assign hdr_in  = hdr_t'(bus.noc0_ctovr_cfg_data[NOC_DATA_W-1 -: HDR_W]);
    assign body_in = body_t'(bus.noc0_ctovr_cfg_data[NOC_DATA_W-1 -: BODY_W]);
    assign unused_bits = ^{hdr_in.dst_x, hdr_in.dst_y,
                           bus.noc0_ctovr_cfg_data[NOC_DATA_W-BODY_W-1:0]};

    // run_q keeps rdy low while reset is asserted so every output idles at 0.
    assign rdy = run_q && ((state_q == ST_RX_HDR) || (state_q == ST_DRAIN) ||
                           (state_q == ST_RX_BODY));
    assign accept = bus.noc0_ctovr_cfg_val && rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RX_HDR;
            run_q   <= 1'b0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        wr_fire   = 1'b0;
        ack_en    = 1'b0;
        hdr_ld    = 1'b0;
        body_ld   = 1'b0;
        status_ld = 1'b0;
        status_d  = STS_OK;
        case (state_q)
            ST_RX_HDR: begin
                if (accept) begin
                    hdr_ld = 1'b1;
                    if ((hdr_in.msg_type == MSG_CFG) && (hdr_in.msg_len == 8'd1)) begin
                        state_d = ST_RX_BODY;
                    end else begin
                        status_ld = 1'b1;
                        status_d  = STS_BAD_MSG;
                        if (hdr_in.msg_len == 8'd0) begin
                            state_d = ST_TX_ACK;
                        end else begin
                            drain_d = hdr_in.msg_len;
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    drain_d = drain_q - 8'd1;
                    if (drain_q == 8'd1) begin
                        state_d = ST_TX_ACK;
                    end
                end
            end
            ST_RX_BODY: begin
                if (accept) begin
                    body_ld = 1'b1;
                    if (!op_valid(body_in.op)) begin
                        status_ld = 1'b1;
                        status_d  = STS_BAD_OP;
                        state_d   = ST_TX_ACK;
                    end else if (32'(body_in.idx) >= NUM_ENTRIES) begin
                        status_ld = 1'b1;
                        status_d  = STS_BAD_IDX;
                        state_d   = ST_TX_ACK;
                    end else begin
                        state_d = ST_CAM_WR;
                    end
                end
            end
            ST_CAM_WR: begin
                // The RX lookup always wins; the write simply waits.
                wr_fire = !bus.rd_cam_val;
                if (wr_fire) begin
                    status_ld = 1'b1;
                    status_d  = STS_OK;
                    state_d   = ST_TX_ACK;
                end
            end
            ST_TX_ACK: begin
                ack_en = 1'b1;
                if (bus.noc0_vrtoc_cfg_rdy) begin
                    state_d = ST_RX_HDR;
                end
            end
            default: begin
                state_d = ST_RX_HDR;
            end
        endcase
    end

    assign bus.cfg_noc0_ctovr_rdy = rdy;
    assign bus.cfg_noc0_vrtoc_val = ack_en;
    assign bus.cfg_cam_wr_val     = wr_fire;

    eth_rx_cam_cfg_datap #(
        .NOC_DATA_W (NOC_DATA_W),
        .XY_W       (XY_W),
        .ETH_TYPE_W (ETH_TYPE_W),
        .IDX_W      (IDX_W),
        .SRC_X      (SRC_X),
        .SRC_Y      (SRC_Y)
    ) u_datap (
        .clk          (clk),
        .rst_n        (rst_n),
        .hdr_ld       (hdr_ld),
        .src_x_in     (hdr_in.src_x),
        .src_y_in     (hdr_in.src_y),
        .body_ld      (body_ld),
        .op_in        (body_in.op),
        .idx_in       (body_in.idx[IDX_W-1:0]),
        .tag_in       (body_in.tag),
        .dst_in       ({body_in.dst_x, body_in.dst_y}),
        .status_ld    (status_ld),
        .status_in    (status_d),
        .cnt_inc      (wr_fire),
        .ack_en       (ack_en),
        .cam_wr_clear (bus.cfg_cam_wr_clear),
        .cam_wr_idx   (bus.cfg_cam_wr_idx),
        .cam_wr_tag   (bus.cfg_cam_wr_tag),
        .cam_wr_data  (bus.cfg_cam_wr_data),
        .ack_data     (bus.cfg_noc0_vrtoc_data),
        .wr_count     (bus.cfg_wr_count)
    );

endmodule

// File: doc/eth_rx_cam_cfg_ctrl.md
Name: eth_rx_cam_cfg_ctrl

Overview:
Programs the EtherType-to-destination steering CAM used by the eth RX NoC-out path. It receives configuration messages from noc0 and decodes them into CAM write or invalidate operations. Each write is arbitrated against the live RX lookup port, and every message is answered with a single-flit ack. It sits beside the eth RX tile's NoC-out path and owns the CAM write port.

Parameters:
SRC_X, -1, tile X coordinate; source of ack flits
SRC_Y, -1, tile Y coordinate; source of ack flits
NOC_DATA_W, 512, noc flit width
XY_W, 4, width of one NoC coordinate
ETH_TYPE_W, 16, CAM tag width
NUM_ENTRIES, 8, CAM depth; the index width is IDX_W = clog2(NUM_ENTRIES)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
noc0_ctovr_cfg_val  in  1  incoming config flit valid
noc0_ctovr_cfg_data  in  NOC_DATA_W  incoming config flit
cfg_noc0_ctovr_rdy  out  1  incoming flit accept
cfg_noc0_vrtoc_val  out  1  ack flit valid
cfg_noc0_vrtoc_data  out  NOC_DATA_W  ack flit
noc0_vrtoc_cfg_rdy  in  1  ack flit accept
rd_cam_val  in  1  RX lookup in progress this cycle; the reader has priority
cfg_cam_wr_val  out  1  CAM write strobe (one cycle)
cfg_cam_wr_clear  out  1  1 = invalidate entry, 0 = write entry
cfg_cam_wr_idx  out  IDX_W  entry index
cfg_cam_wr_tag  out  ETH_TYPE_W  EtherType tag
cfg_cam_wr_data  out  2*XY_W  destination {x,y}
cfg_wr_count  out  16  count of successful CAM ops; wraps at 16 bits

Behaviour:
Header flit layout, MSB first:
- dst_x, dst_y, src_x, src_y (XY_W each)
- msg_len[7:0]: number of body flits
- msg_type[7:0]: CFG = 8'h30, ACK = 8'h31
- remainder zero
Body flit layout, MSB first:
- op[1:0]: 01 = write, 10 = invalidate, 00/11 = bad op
- idx[7:0]
- tag[ETH_TYPE_W-1:0]
- dst_x, dst_y
Ack flit:
- header layout with dst = received src, src = {SRC_X,SRC_Y}, msg_len = 0, msg_type = ACK
- status[1:0] in bits [1:0]: 00 = OK, 01 = BAD_MSG, 10 = BAD_OP, 11 = BAD_IDX
Reset (rst_n low, asynchronous):
- state = RX_HDR; all outputs 0; cfg_wr_count = 0; latched fields = 0.
- Reset mid-message abandons the message; no partial CAM write and no ack.
FSM:
- RX_HDR: rdy = 1. On val & rdy, latch src and msg_len.
  - msg_type == CFG and msg_len == 1: go to RX_BODY.
  - Any other header with msg_len == 0: status = BAD_MSG, go to TX_ACK.
  - Any other header with msg_len != 0: status = BAD_MSG, drain counter = msg_len, go to DRAIN.
- DRAIN: rdy = 1. Decrement the counter on each accepted flit; go to TX_ACK when it reaches 0.
- RX_BODY: rdy = 1. On accept, latch op, idx, tag, dst.
  - op invalid: status = BAD_OP, go to TX_ACK.
  - idx >= NUM_ENTRIES: status = BAD_IDX, go to TX_ACK.
  - otherwise: go to CAM_WR.
- CAM_WR: rdy = 0.
  - cfg_cam_wr_val = !rd_cam_val, evaluated combinationally.
  - When the strobe fires: cfg_wr_count += 1, status = OK, go to TX_ACK.
  - While rd_cam_val stays high the write is deferred with no timeout.
  - wr_clear/idx/tag/data are held stable throughout CAM_WR.
- TX_ACK: rdy = 0, vrtoc_val = 1, data is stable.
  - On noc0_vrtoc_cfg_rdy, go to RX_HDR.
  - Backpressure holds the flit indefinitely.
Cycle counts, no stalls:
- Good message: header accepted in cycle 0, body in cycle 1, write in cycle 2, ack valid in cycle 3.
- cfg_noc0_ctovr_rdy is never high outside RX_HDR, DRAIN and RX_BODY.
- Never more than one message in flight.

Decomposition:
eth_rx_cfg_pkg holds:
- the state enum
- CFG/ACK msg_type constants
- the op and status enums
- packed structs for the header and body flit layouts
Sub-module: eth_rx_cam_cfg_datap holds:
- input latch registers
- ack flit assembly
- cfg_wr_count
The control FSM stays in the top-level block.

Test Plan:
- Write entry: CFG header from src (2,3), body op = 01, idx = 3, tag = 16'h0800, dst = (1,0) -> in cycle 2, wr_val = 1 with idx = 3, tag = 0800, data = 8'h10; ack to (2,3) with status 00; count = 1.
- Lookup collision: same write with rd_cam_val high for 4 cycles -> wr_val stays low for 4 cycles and pulses in the 5th; exactly one write.
- Bad index: idx = 8 with NUM_ENTRIES = 8 -> no wr_val; ack status 11; count unchanged.
- Bad message: msg_type = 8'h55, msg_len = 3 -> 3 body flits drained, no wr_val, ack status 01; the next good message is handled normally.
- Ack backpressure: vrtoc_rdy low for 10 cycles -> ack data stable, ctovr_rdy = 0 throughout, new header accepted only after the ack handshake.
- Reset mid-body: assert rst_n low during RX_BODY -> all outputs 0 immediately, no write or ack afterwards, count = 0.
- Counter wrap: preload 16'hFFFF writes -> next write sets count = 0.
